seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Time-multiplexed scan controller for a common-segment multi-digit 7-segment display. It shares a single 4-bit segment decoder (SegDisplay) among NUM_DIGITS digits by cycling one digit enable at a time. Each digit slot has a blanking guard interval to suppress ghosting. New display values arrive through a valid/ready handshake and take effect only at frame boundaries, so a frame never shows a mix of old and new values. It sits between the value-producing logic and the display pins.

## Interface
- NUM_DIGITS, 4, digits scanned; legal 1..8
- REFRESH_DIV, 50000, cycles a digit is driven per slot; ≥1
- GUARD_CYCLES, 16, all-off cycles before each drive phase; ≥1
- DIGIT_ACTIVE_LOW, 1, 1: digit_en bit = 0 means the digit is on
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- load_valid  in  1  load_data offered
- load_ready  out  1  pending buffer empty; load accepted when valid&&ready
- load_data  in  4*NUM_DIGITS  nibble k shows on digit k (digit 0 = bits [3:0])
- blank_mask  in  NUM_DIGITS  bit k = 1 forces digit k dark
- seg_out  out  7  segment drive from the decoder (active-low, 7'h7F = all off)
- digit_en  out  NUM_DIGITS  one-hot digit enable, polarity per DIGIT_ACTIVE_LOW
- frame_done  out  1  one-cycle pulse at end of the last digit's drive phase

## Operation
- Registers:
  - disp_reg: committed value.
  - pend_reg + pend_valid: one-deep pending buffer.
  - digit_idx.
  - cycle counter.
  - state.
- FSM states:
  - GUARD: all digits off, seg_out = 7'h7F, for GUARD_CYCLES cycles.
  - DRIVE: enable digit digit_idx and output the decoded nibble, for REFRESH_DIV cycles.
- Transitions:
  - GUARD → DRIVE when the counter reaches GUARD_CYCLES-1.
  - DRIVE → GUARD when the counter reaches REFRESH_DIV-1.
  - On leaving DRIVE, digit_idx increments. At NUM_DIGITS-1 it wraps to 0.
- Wrap cycle (leaving DRIVE of digit NUM_DIGITS-1):
  - frame_done pulses.
  - If pend_valid: disp_reg ← pend_reg and pend_valid clears.
- Handshake:
  - load_ready = ~pend_valid.
  - On acceptance: pend_reg ← load_data, pend_valid ← 1.
  - A load accepted on the wrap cycle itself is not committed that cycle. It commits at the next frame boundary.
  - A second load stalls (ready low) until the commit.
- blank_mask is sampled on the GUARD→DRIVE transition and held for the slot. A masked digit stays off with seg_out = 7'h7F for the whole DRIVE phase; timing is unchanged.
- NUM_DIGITS = 1: digit_idx stays 0, and every slot end is a wrap.
- Reset (any time, including mid-slot):
  - state = GUARD, counter = 0, digit_idx = 0.
  - disp_reg = 0, pend_valid = 0 (the pending value is discarded).
  - seg_out = 7'h7F, all digits off (digit_en = all-1s if DIGIT_ACTIVE_LOW, else 0).
  - frame_done = 0, load_ready = 1 after reset.

## Timing
- seg_out, digit_en and frame_done are registered. seg_out and digit_en change on the same edge, so no cycle ever has a digit on with a stale segment value.
- After rst_n deasserts:
  - The first GUARD phase runs GUARD_CYCLES cycles.
  - Digit 0 is on for the next REFRESH_DIV cycles.
- Periods:
  - Slot period: GUARD_CYCLES + REFRESH_DIV.
  - Frame period: NUM_DIGITS × slot period.
- Load-to-display latency: from acceptance to the next wrap, then one GUARD phase before digit 0 shows the new value.
- Counter width: $clog2(max(REFRESH_DIV, GUARD_CYCLES)); digit_idx width: $clog2(NUM_DIGITS) (min 1). No overflow is possible, because terminal-count compare resets the counter.

## Structure
- Shared package seg_pkg holds:
  - SEG_BLANK = 7'h7F.
  - The state enum {GUARD, DRIVE}.
  - A helper returning the all-off digit_en pattern for a given polarity.
- One sub-module instance: SegDisplay. Its 4-bit input is disp_reg nibble digit_idx; its output is registered into seg_out.
- All other logic sits in one always_ff plus next-state combinational logic, roughly 150–250 lines.

## Test plan
All scenarios use NUM_DIGITS=4, REFRESH_DIV=4, GUARD_CYCLES=2, DIGIT_ACTIVE_LOW=1.
- Reset scenario:
  - Stimulus: hold rst_n low; release.
  - Required: seg_out=7'h7F and digit_en=4'hF while held. First digit_en=4'hE appears exactly 2 cycles after release and lasts 4 cycles, with seg_out=7'h40 (digit 0).
- Load and scan:
  - Stimulus: load 16'h1234.
  - Required: after the next wrap, digit 0 shows 7'b0011001 ("4"), digit 1 shows 7'b0110000 ("3"). frame_done pulses every 24 cycles.
- Back-to-back loads:
  - Stimulus: offer 16'h1111 then 16'h2222 on consecutive cycles.
  - Required: the second is held off (load_ready=0) until the wrap cycle. Display shows 1111 for a full frame, then 2222. There is never a mixed frame.
- Blanking:
  - Stimulus: blank_mask=4'b0100.
  - Required: during slot 2, digit_en=4'hF and seg_out=7'h7F for all 4 drive cycles; the other slots are unaffected.
- Mid-slot reset:
  - Stimulus: assert rst_n during digit 2's DRIVE with a pending load.
  - Required: outputs blank immediately (asynchronously). After release, the scan restarts at digit 0 showing 0, and the pending value is gone.
- Wrap-cycle load:
  - Stimulus: accept a load exactly on the frame_done cycle.
  - Required: the value commits one frame later, not immediately.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed 7-segment scan controller:
// blank segment pattern, scan FSM states and the all-off digit-enable helper.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam int         MAX_DIGITS = 8;

    typedef enum logic {
        GUARD = 1'b0,
        DRIVE = 1'b1
    } state_t;

    // All-off enable pattern, full MAX_DIGITS width; callers truncate.
    function automatic logic [MAX_DIGITS-1:0] digit_off(input bit active_low);
        return active_low ? {MAX_DIGITS{1'b1}} : {MAX_DIGITS{1'b0}};
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_segdisplay.sv
// Hex nibble to active-low 7-segment pattern ({g,f,e,d,c,b,a}, 0 = lit).
// Purely combinational; the scan controller registers the result.
module SegDisplay (
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = 7'h7F;
        case (i_nibble)
            4'h0: o_seg = 7'b1000000;
            4'h1: o_seg = 7'b1111001;
            4'h2: o_seg = 7'b0100100;
            4'h3: o_seg = 7'b0110000;
            4'h4: o_seg = 7'b0011001;
            4'h5: o_seg = 7'b0010010;
            4'h6: o_seg = 7'b0000010;
            4'h7: o_seg = 7'b1111000;
            4'h8: o_seg = 7'b0000000;
            4'h9: o_seg = 7'b0010000;
            4'hA: o_seg = 7'b0001000;
            4'hB: o_seg = 7'b0000011;
            4'hC: o_seg = 7'b1000110;
            4'hD: o_seg = 7'b0100001;
            4'hE: o_seg = 7'b0000110;
            4'hF: o_seg = 7'b0001110;
            default: o_seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller: GUARD (all dark) then DRIVE per digit,
// with a one-deep pending load buffer committed only at frame boundaries.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS       = 4,
    parameter int REFRESH_DIV      = 50000,
    parameter int GUARD_CYCLES     = 16,
    parameter bit DIGIT_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_done
);

    localparam int CNT_MAX = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] DRV_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GRD_LAST = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] EN_OFF = NUM_DIGITS'(digit_off(DIGIT_ACTIVE_LOW));

    state_t                  r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;

    logic [4*NUM_DIGITS-1:0] r_disp;
    logic [4*NUM_DIGITS-1:0] r_pend;
    logic                    r_pend_valid;
    logic                    r_masked;
    logic [6:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_en;
    logic                    r_fd;

    state_t                  w_state_nxt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic [IDX_W-1:0]        w_idx_nxt;
    logic                    w_guard_end;
    logic                    w_slot_end;
    logic                    w_wrap;
    logic                    w_accept;
    logic                    w_masked_nxt;
    logic [6:0]              w_seg_nxt;
    logic [NUM_DIGITS-1:0]   w_en_nxt;
    logic                    w_fd_nxt;
    logic [NUM_DIGITS-1:0]   w_onehot;
    logic [3:0]              w_nibble;
    logic [6:0]              w_dec;

    assign w_nibble = r_disp[{r_idx, 2'b00} +: 4];
    assign w_onehot = NUM_DIGITS'(1) << r_idx;
    assign w_accept = load_valid && !r_pend_valid;

    SegDisplay u_dec (
        .i_nibble (w_nibble),
        .o_seg    (w_dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= GUARD;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Terminal-count compares reset the counter, so it never wraps on its own.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_idx_nxt   = r_idx;
        w_guard_end = (r_state == GUARD) && (r_cnt == GRD_LAST);
        w_slot_end  = (r_state == DRIVE) && (r_cnt == DRV_LAST);
        w_wrap      = w_slot_end && (r_idx == IDX_LAST);
        if (w_guard_end) begin
            w_state_nxt = DRIVE;
            w_cnt_nxt   = '0;
        end else if (w_slot_end) begin
            w_state_nxt = GUARD;
            w_cnt_nxt   = '0;
            w_idx_nxt   = w_wrap ? '0 : r_idx + 1'b1;
        end
    end

    // Outputs are computed from next-state values so that segments and
    // enables switch on the same edge as the phase change.
    always_comb begin
        w_masked_nxt = r_masked;
        w_seg_nxt    = SEG_BLANK;
        w_en_nxt     = EN_OFF;
        if (w_guard_end)
            w_masked_nxt = blank_mask[r_idx];
        if ((w_state_nxt == DRIVE) && !w_masked_nxt) begin
            w_seg_nxt = w_dec;
            w_en_nxt  = DIGIT_ACTIVE_LOW ? ~w_onehot : w_onehot;
        end
        w_fd_nxt = (w_state_nxt == DRIVE) && (w_cnt_nxt == DRV_LAST) &&
                   (w_idx_nxt == IDX_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp       <= '0;
            r_pend       <= '0;
            r_pend_valid <= 1'b0;
            r_masked     <= 1'b0;
            r_seg        <= SEG_BLANK;
            r_en         <= EN_OFF;
            r_fd         <= 1'b0;
        end else begin
            // A commit needs pend_valid, an accept needs it clear: never both.
            if (w_wrap && r_pend_valid) begin
                r_disp       <= r_pend;
                r_pend_valid <= 1'b0;
            end else if (w_accept) begin
                r_pend       <= load_data;
                r_pend_valid <= 1'b1;
            end
            r_masked <= w_masked_nxt;
            r_seg    <= w_seg_nxt;
            r_en     <= w_en_nxt;
            r_fd     <= w_fd_nxt;
        end
    end

    assign load_ready = !r_pend_valid;
    assign seg_out    = r_seg;
    assign digit_en   = r_en;
    assign frame_done = r_fd;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with 4 digits, 4-cycle drive, 2-cycle guard
// (slot = 6 cycles, frame = 24 cycles).
module tb_seg_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_data;
    logic [3:0]  blank_mask;
    logic [6:0]  seg_out;
    logic [3:0]  digit_en;
    logic        frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    seg_scan_ctrl #(
        .NUM_DIGITS       (4),
        .REFRESH_DIV      (4),
        .GUARD_CYCLES     (2),
        .DIGIT_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .blank_mask (blank_mask),
        .seg_out    (seg_out),
        .digit_en   (digit_en),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference active-low 7-segment patterns, {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;
            4'h3: return 7'h30;  4'h4: return 7'h19;  4'h5: return 7'h12;
            4'h6: return 7'h02;  4'h7: return 7'h78;  4'h8: return 7'h00;
            4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Checks frame cycles first_j..24, where j=1 is the cycle after a frame_done.
    task automatic check_frame(input logic [15:0] val, input logic [3:0] mask,
                               input int first_j, input string name);
        logic [6:0] e_seg;
        logic [3:0] e_en;
        logic [3:0] oh;
        logic       e_fd;
        int         s;
        int         p;
        for (int j = first_j; j <= 24; j++) begin
            step();
            s = (j - 1) / 6;
            p = (j - 1) % 6;
            if (p < 2 || mask[s]) begin
                e_seg = 7'h7F;
                e_en  = 4'hF;
            end else begin
                e_seg = seg_of(val[s*4 +: 4]);
                oh    = 4'b0001 << s;
                e_en  = ~oh;
            end
            e_fd = (j == 24);
            n_checks++;
            if ({seg_out, digit_en, frame_done} !== {e_seg, e_en, e_fd}) begin
                n_fail++;
                $display("FAIL %s j=%0d: got seg=%h en=%h fd=%b, expected seg=%h en=%h fd=%b",
                         name, j, seg_out, digit_en, frame_done, e_seg, e_en, e_fd);
            end
        end
    endtask

    task automatic wait_fd(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            if (frame_done) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s: frame_done got 0 within 40 cycles, expected 1", name);
        end
    endtask

    // Called right after rst_n is released on a falling edge.
    task automatic check_startup(input string name);
        logic [6:0] e_seg;
        logic [3:0] e_en;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k >= 2 && k <= 5) begin
                e_seg = 7'h40; e_en = 4'hE;
            end else if (k >= 8) begin
                e_seg = 7'h40; e_en = 4'hD;
            end else begin
                e_seg = 7'h7F; e_en = 4'hF;
            end
            n_checks++;
            if ({seg_out, digit_en, frame_done} !== {e_seg, e_en, 1'b0}) begin
                n_fail++;
                $display("FAIL %s k=%0d: got seg=%h en=%h fd=%b, expected seg=%h en=%h fd=0",
                         name, k, seg_out, digit_en, frame_done, e_seg, e_en);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (seg_out !== 7'h7F) begin n_fail++; $display("FAIL reset_seg: got %h, expected 7f", seg_out); end
        n_checks++;
        if (digit_en !== 4'hF) begin n_fail++; $display("FAIL reset_en: got %h, expected f", digit_en); end
        n_checks++;
        if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_fd: got %b, expected 0", frame_done); end
        n_checks++;
        if (load_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b, expected 1", load_ready); end
        rst_n = 1'b1;
        check_startup("startup");
    endtask

    task automatic test_load_scan();
        n_checks++;
        if (load_ready !== 1'b1) begin n_fail++; $display("FAIL load_ready_idle: got %b, expected 1", load_ready); end
        load_valid = 1'b1;
        load_data  = 16'h1234;
        step();
        load_valid = 1'b0;
        n_checks++;
        if (load_ready !== 1'b0) begin n_fail++; $display("FAIL load_ready_pend: got %b, expected 0", load_ready); end
        wait_fd("load_wrap");
        check_frame(16'h1234, 4'h0, 1, "scan_1234");
    endtask

    task automatic test_back_to_back();
        bit last_fd = 1'b0;
        bit rose    = 1'b0;
        repeat (3) step();
        load_valid = 1'b1;
        load_data  = 16'h1111;
        step();
        load_data = 16'h2222;
        n_checks++;
        if (load_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_stall: got ready=%b, expected 0", load_ready); end
        for (int i = 0; i < 40 && !rose; i++) begin
            last_fd = frame_done;
            step();
            if (load_ready) rose = 1'b1;
        end
        n_checks++;
        if (!rose || !last_fd) begin
            n_fail++;
            $display("FAIL b2b_release: got ready=%b prev_fd=%b, expected ready=1 right after frame_done", load_ready, last_fd);
        end
        check_frame(16'h1111, 4'h0, 2, "b2b_1111");
        load_valid = 1'b0;
        n_checks++;
        if (load_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_second_pend: got %b, expected 0", load_ready); end
        check_frame(16'h2222, 4'h0, 1, "b2b_2222");
    endtask

    task automatic test_wrap_load();
        n_checks++;
        if (frame_done !== 1'b1 || load_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_setup: got fd=%b ready=%b, expected 1 1", frame_done, load_ready);
        end
        load_valid = 1'b1;
        load_data  = 16'h5678;
        step();
        load_valid = 1'b0;
        n_checks++;
        if ({load_ready, seg_out, digit_en} !== {1'b0, 7'h7F, 4'hF}) begin
            n_fail++;
            $display("FAIL wrap_accept: got ready=%b seg=%h en=%h, expected 0 7f f", load_ready, seg_out, digit_en);
        end
        check_frame(16'h2222, 4'h0, 2, "wrap_old");
        check_frame(16'h5678, 4'h0, 1, "wrap_new");
    endtask

    task automatic test_blank();
        blank_mask = 4'b0100;
        check_frame(16'h5678, 4'b0100, 1, "blank");
        blank_mask = 4'b0000;
    endtask

    task automatic test_mid_reset();
        step();
        load_valid = 1'b1;
        load_data  = 16'hABCD;
        step();
        load_valid = 1'b0;
        n_checks++;
        if (load_ready !== 1'b0) begin n_fail++; $display("FAIL mid_pend: got %b, expected 0", load_ready); end
        repeat (14) step();
        n_checks++;
        if ({seg_out, digit_en} !== {7'h02, 4'hB}) begin
            n_fail++;
            $display("FAIL mid_drive2: got seg=%h en=%h, expected 02 b", seg_out, digit_en);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({seg_out, digit_en, frame_done, load_ready} !== {7'h7F, 4'hF, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL mid_async: got seg=%h en=%h fd=%b ready=%b, expected 7f f 0 1",
                     seg_out, digit_en, frame_done, load_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_startup("mid_restart");
        wait_fd("mid_wrap");
        check_frame(16'h0000, 4'h0, 1, "mid_discard");
    endtask

    initial begin
        rst_n      = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        blank_mask = '0;
        test_reset();
        test_load_scan();
        test_back_to_back();
        test_wrap_load();
        test_blank();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
